mem_receiver: RTL and testbench

- Load-data formatter on the memory-read return path of a RV32I-style core.
- Takes the 32-bit word read from data memory, the two address LSBs and the load func3.
- Selects the addressed byte or halfword, then sign- or zero-extends it to 32 bits.
- Registers the result for the writeback stage, with valid and error flags.

---
 rtl/mem_receiver.sv | 116 +++++++++++
 tb/tb_mem_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_receiver.sv
// ---------------------------------------------------------------------------
// mem_receiver
// Load-data formatter on the memory-read return path of an RV32I-style core.
// It takes the aligned word from data memory, picks out the addressed byte or
// halfword, and sign- or zero-extends it to XLEN bits. The result is
// registered for the writeback stage together with valid and error flags.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   read_data/Addr2Lsb/func3 are valid this cycle
//   read_data  in   [XLEN-1:0] aligned word returned by data memory
//   Addr2Lsb   in   [1:0] address bits [1:0] of the load
//   func3      in   [2:0] load type (LB, LH, LW, LBU, LHU)
//   load_word  out  [XLEN-1:0] formatted, extended load result (registered)
//   valid_out  out  valid_in delayed by one cycle
//   misaligned out  halfword at an odd address, or word at a non-zero offset
//   illegal    out  func3 is not a load encoding (011, 110, 111)
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module mem_receiver #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_in,
   input  logic [XLEN-1:0] read_data,
   input  logic [1:0]      Addr2Lsb,
   input  logic [2:0]      func3,
   output logic [XLEN-1:0] load_word,
   output logic            valid_out,
   output logic            misaligned,
   output logic            illegal
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [XLEN-1:0] load_word_q,  load_word_d;
   logic            valid_q,      valid_d;
   logic            misaligned_q, misaligned_d;
   logic            illegal_q,    illegal_d;

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Lane selection is done unconditionally; func3 decides which one is used.
   always_comb begin
      sel_byte = read_data[7:0];
      case (Addr2Lsb)
         2'b00: sel_byte = read_data[7:0];
         2'b01: sel_byte = read_data[15:8];
         2'b10: sel_byte = read_data[23:16];
         2'b11: sel_byte = read_data[31:24];
         default: sel_byte = read_data[7:0];
      endcase
      // Addr2Lsb[0] never shifts halfword data; a halfword is not split.
      sel_half = Addr2Lsb[1] ? read_data[31:16] : read_data[15:0];
   end

   // Next-state: the data registers only load when valid_in is high, so
   // idle cycles leave the previous result and flags visible.
   always_comb begin
      load_word_d  = load_word_q;
      misaligned_d = misaligned_q;
      illegal_d    = illegal_q;
      valid_d      = valid_in;
      if (valid_in) begin
         misaligned_d = 1'b0;
         illegal_d    = 1'b0;
         case (func3)
            F3_LB:  load_word_d = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU: load_word_d = {24'd0, sel_byte};
            F3_LH: begin
               load_word_d  = {{16{sel_half[15]}}, sel_half};
               misaligned_d = Addr2Lsb[0];
            end
            F3_LHU: begin
               load_word_d  = {16'd0, sel_half};
               misaligned_d = Addr2Lsb[0];
            end
            F3_LW: begin
               load_word_d  = read_data;
               misaligned_d = |Addr2Lsb;
            end
            default: begin
               load_word_d = '0;
               illegal_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_word_q  <= '0;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         load_word_q  <= load_word_d;
         valid_q      <= valid_d;
         misaligned_q <= misaligned_d;
         illegal_q    <= illegal_d;
      end
   end

   assign load_word  = load_word_q;
   assign valid_out  = valid_q;
   assign misaligned = misaligned_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_mem_receiver.sv
// ---------------------------------------------------------------------------
// tb_mem_receiver
// Self-checking bench for mem_receiver. A behavioural model computes the
// expected load result arithmetically (shift/mask, two's-complement
// adjustment) and tracks the registered outputs; a compare process checks
// every output on every falling edge. Directed sequences add literal
// expectations for the documented example loads, hold behaviour and reset.
// ---------------------------------------------------------------------------
module tb_mem_receiver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        valid_in = 1'b0;
   logic [31:0] read_data = '0;
   logic [1:0]  Addr2Lsb = '0;
   logic [2:0]  func3 = '0;
   logic [31:0] load_word;
   logic        valid_out;
   logic        misaligned;
   logic        illegal;

   int checks = 0;
   int passes = 0;

   typedef struct packed {
      logic [31:0] word;
      logic        mis;
      logic        ill;
   } result_t;

   logic [31:0] exp_word  = '0;
   logic        exp_valid = 1'b0;
   logic        exp_mis   = 1'b0;
   logic        exp_ill   = 1'b0;

   mem_receiver #(.XLEN(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .valid_in(valid_in),
      .read_data(read_data),
      .Addr2Lsb(Addr2Lsb),
      .func3(func3),
      .load_word(load_word),
      .valid_out(valid_out),
      .misaligned(misaligned),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference load formatter: shift the addressed lane down, mask it, and
   // for signed loads subtract the lane's range when its top bit is set.
   function automatic result_t model(input logic [31:0] data,
                                     input logic [1:0] addr,
                                     input logic [2:0] f3);
      result_t     r;
      logic [31:0] b;
      logic [31:0] h;
      int          off;
      off = int'(addr);
      b = (data >> (8 * off)) & 32'h0000_00FF;
      h = (data >> ((off >= 2) ? 16 : 0)) & 32'h0000_FFFF;
      r.word = '0;
      r.mis  = 1'b0;
      r.ill  = 1'b0;
      case (int'(f3))
         0: r.word = (b >= 32'd128) ? b - 32'd256 : b;
         1: begin
            r.word = (h >= 32'd32768) ? h - 32'd65536 : h;
            r.mis  = (off % 2) != 0;
         end
         2: begin
            r.word = data;
            r.mis  = off != 0;
         end
         4: r.word = b;
         5: begin
            r.word = h;
            r.mis  = (off % 2) != 0;
         end
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   // Model of the registered outputs: one-cycle delay, hold when idle,
   // asynchronous clear on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_word  <= '0;
         exp_valid <= 1'b0;
         exp_mis   <= 1'b0;
         exp_ill   <= 1'b0;
      end else begin
         exp_valid <= valid_in;
         if (valid_in) begin
            exp_word <= model(read_data, Addr2Lsb, func3).word;
            exp_mis  <= model(read_data, Addr2Lsb, func3).mis;
            exp_ill  <= model(read_data, Addr2Lsb, func3).ill;
         end
      end
   end

   task automatic compare(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Continuous check of every output against the model.
   always @(negedge clk) begin
      compare("cmp.valid_out",  {31'd0, valid_out},  {31'd0, exp_valid});
      compare("cmp.load_word",  load_word,           exp_word);
      compare("cmp.misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      compare("cmp.illegal",    {31'd0, illegal},    {31'd0, exp_ill});
   end

   task automatic applyStimulus(input logic v, input logic [31:0] d,
                                input logic [1:0] a, input logic [2:0] f);
      @(negedge clk);
      valid_in  = v;
      read_data = d;
      Addr2Lsb  = a;
      func3     = f;
   endtask

   // Checks the result of the input applied at the preceding negedge.
   task automatic checkOutput(input string name, input logic v,
                              input logic [31:0] w, input logic m,
                              input logic i);
      @(posedge clk);
      #1;
      compare({name, ".valid"}, {31'd0, valid_out},  {31'd0, v});
      compare({name, ".word"},  load_word,           w);
      compare({name, ".mis"},   {31'd0, misaligned}, {31'd0, m});
      compare({name, ".ill"},   {31'd0, illegal},    {31'd0, i});
   endtask

   initial begin
      logic [31:0] lbu_exp [4];
      logic [31:0] lh_exp  [4];
      logic        lh_mis  [4];
      lbu_exp = '{32'h0000_0078, 32'h0000_0056, 32'h0000_0034, 32'h0000_0012};
      lh_exp  = '{32'h0000_5678, 32'h0000_5678, 32'h0000_1234, 32'h0000_1234};
      lh_mis  = '{1'b0, 1'b1, 1'b0, 1'b1};

      #1 rst_n = 1'b0;

      // Reset held with valid_in toggling: outputs stay cleared.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], 32'hDEAD_BEEF, 2'b11, 3'b010);
         checkOutput("reset_hold", 1'b0, 32'd0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 32'h1234_5678, 2'b01, 3'b100);
      rst_n = 1'b1;
      checkOutput("post_reset_idle", 1'b0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h1234_5678, 2'b01, 3'b100);
      checkOutput("first_valid", 1'b1, 32'h0000_0056, 1'b0, 1'b0);

      // LBU sweep, back-to-back.
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b1, 32'h1234_5678, 2'(a), 3'b100);
         checkOutput("lbu_sweep", 1'b1, lbu_exp[a], 1'b0, 1'b0);
      end

      // LH and LHU sweeps.
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b1, 32'h1234_5678, 2'(a), 3'b001);
         checkOutput("lh_sweep", 1'b1, lh_exp[a], lh_mis[a], 1'b0);
      end
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b1, 32'h1234_5678, 2'(a), 3'b101);
         checkOutput("lhu_sweep", 1'b1, lh_exp[a], lh_mis[a], 1'b0);
      end

      // Sign extension.
      applyStimulus(1'b1, 32'h80F0_7F8C, 2'b00, 3'b000);
      checkOutput("lb_neg", 1'b1, 32'hFFFF_FF8C, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h80F0_7F8C, 2'b01, 3'b000);
      checkOutput("lb_pos", 1'b1, 32'h0000_007F, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h80F0_7F8C, 2'b00, 3'b100);
      checkOutput("lbu_8c", 1'b1, 32'h0000_008C, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h80F0_7F8C, 2'b10, 3'b001);
      checkOutput("lh_neg", 1'b1, 32'hFFFF_80F0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h80F0_7F8C, 2'b10, 3'b101);
      checkOutput("lhu_80f0", 1'b1, 32'h0000_80F0, 1'b0, 1'b0);

      // Word and illegal encodings.
      applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b00, 3'b010);
      checkOutput("lw_aligned", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b10, 3'b010);
      checkOutput("lw_misaligned", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b00, 3'b011);
      checkOutput("illegal_011", 1'b1, 32'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b01, 3'b111);
      checkOutput("illegal_111", 1'b1, 32'd0, 1'b0, 1'b1);

      // Hold: idle cycles with changing inputs keep the last result.
      applyStimulus(1'b1, 32'h1234_5678, 2'b00, 3'b100);
      checkOutput("hold_load", 1'b1, 32'h0000_0078, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, $urandom, 2'($urandom), 3'b010);
         checkOutput("hold_idle", 1'b0, 32'h0000_0078, 1'b0, 1'b0);
      end

      // Reset asserted mid-cycle clears outputs at once.
      applyStimulus(1'b1, 32'hDEAD_BEEF, 2'b01, 3'b010);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      compare("async_reset.valid", {31'd0, valid_out},  32'd0);
      compare("async_reset.word",  load_word,           32'd0);
      compare("async_reset.mis",   {31'd0, misaligned}, 32'd0);
      compare("async_reset.ill",   {31'd0, illegal},    32'd0);
      applyStimulus(1'b1, 32'hCAFE_F00D, 2'b00, 3'b010);
      rst_n = 1'b1;
      valid_in = 1'b0;
      checkOutput("reset_discard", 1'b0, 32'd0, 1'b0, 1'b0);

      // Randomised traffic, including illegal encodings and rare reset pulses.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), $urandom,
                       2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 59) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
      applyStimulus(1'b0, 32'd0, 2'b00, 3'b000);
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
